// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: sequencer for a 12-bit (3-digit) BCD incrementor.
//   Owns the BCD count register and prescales clk down to a count tick.
//   On each tick it enables the external incrementor and writes back its result.
//   Command inputs clear/load/stop/start are 1-cycle pulses, in that priority order.
// Optional feature macro: BCD_CTRL_SATURATE_EN
//   Defined: the count stops at 999 and the sequencer drops to HOLD.
//   Undefined: the count wraps 999 -> 000 and pulses wrap.
module bcd_count_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int TICK_W   = $clog2(TICK_DIV) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic [11:0] bcd_next,
  output logic [11:0] bcd_cur,
  output logic        inc_en,
  output logic [11:0] count,
  output logic        running,
  output logic        wrap,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Command bundle, decoded once so the priority chain reads cleanly.
  typedef struct packed {
    logic clr;
    logic ld;
    logic stp;
    logic sta;
  } cmd_t;

  localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [11:0]       BCD_MAX   = 12'h999;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [11:0]       count_q, count_d;
  logic              run_q, run_d;
  logic              wrap_q, wrap_d;
  logic              lerr_q, lerr_d;

  cmd_t              cmd;
  logic [2:0]        dig_ok;
  logic              lv_ok;
  logic              tick;
  logic              at_max;

  assign cmd = '{clr: clear, ld: load, stp: stop, sta: start};

  // Each preset digit {hund,tens,ones} must be a legal BCD value.
  always_comb begin
    dig_ok = '0;
    for (int i = 0; i < 3; i++) begin
      dig_ok[i] = (load_val[4*i +: 4] <= 4'd9);
    end
  end

  assign lv_ok  = &dig_ok;
  assign at_max = (count_q == BCD_MAX);

  // The tick comes from registers only. Commands cannot reach inc_en combinationally.
  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

`ifdef BCD_CTRL_SATURATE_EN
  // Never ask the incrementor to step past 999.
  assign inc_en = tick && !at_max;
`else
  assign inc_en = tick;
`endif

  // Next-state, prescaler and count update, applying the command priority.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (cmd.clr) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = 12'h000;
    end else if (cmd.ld) begin
      // The load restarts the tick period whether or not the preset is accepted.
      presc_d = '0;
      if (lv_ok) count_d = load_val;
      else       lerr_d  = 1'b1;
    end else if (cmd.stp) begin
      // The prescaler is frozen at its current value so a later start resumes mid-period.
      if (state_q == RUN) state_d = HOLD;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (cmd.sta) state_d = RUN;
        end
        HOLD: begin
          if (cmd.sta) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
`ifdef BCD_CTRL_SATURATE_EN
            if (at_max) state_d = HOLD;
            else        count_d = bcd_next;
`else
            count_d = bcd_next;
            wrap_d  = at_max;
`endif
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  assign run_d = (state_d == RUN);

  // State and output registers. An asynchronous reset discards any pending increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= 12'h000;
      run_q   <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      run_q   <= run_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bcd_cur  = count_q;
  assign count    = count_q;
  assign running  = run_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl with TICK_DIV=4.
// The stimulus pushes the expected {count,running,wrap,load_err} events.
// A negedge monitor pops one expected event each time the outputs change and compares them.
module tb_bcd_count_ctrl;

  logic        clk, reset_n;
  logic        start, stop, clear, load;
  logic [11:0] load_val, bcd_next, bcd_cur, count;
  logic        inc_en, running, wrap, load_err;

  typedef struct packed {
    logic [11:0] cnt;
    logic        run;
    logic        wr;
    logic        le;
  } ev_t;

  ev_t exp_q[$];
  ev_t prev, cur;
  int  errors = 0;
  int  checks = 0;
  logic mon_en = 1'b0;

  bcd_count_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .bcd_next(bcd_next), .bcd_cur(bcd_cur),
    .inc_en(inc_en), .count(count), .running(running), .wrap(wrap), .load_err(load_err)
  );

  // Behavioural stand-in for the 3-digit BCD incrementor.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] o, t, h;
    o = v[3:0]; t = v[7:4]; h = v[11:8];
    if (o != 4'd9) o = o + 4'd1;
    else begin
      o = 4'd0;
      if (t != 4'd9) t = t + 4'd1;
      else begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end
    end
    return {h, t, o};
  endfunction

  assign bcd_next = bcd_inc(bcd_cur);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] c, input logic r, input logic w, input logic e);
    exp_q.push_back('{cnt: c, run: r, wr: w, le: e});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic c_clr, input logic c_ld, input logic c_stp,
                       input logic c_sta, input logic [11:0] v);
    clear = c_clr; load = c_ld; stop = c_stp; start = c_sta; load_val = v;
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  // Monitor: each output change must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {count, running, wrap, load_err};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got cnt=%h run=%b wrap=%b lerr=%b, expected no change",
                   cur.cnt, cur.run, cur.wr, cur.le);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event: got cnt=%h run=%b wrap=%b lerr=%b expected cnt=%h run=%b wrap=%b lerr=%b",
                     cur.cnt, cur.run, cur.wr, cur.le, e.cnt, e.run, e.wr, e.le);
          end
        end
        prev = cur;
      end
    end
  end

  // Bound the run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; load_val = 12'h000;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    chk("rst_count", count, 12'h000);
    chk("rst_running", {11'd0, running}, 12'd0);
    chk("rst_inc_en", {11'd0, inc_en}, 12'd0);
    chk("rst_wrap", {11'd0, wrap}, 12'd0);
    chk("rst_load_err", {11'd0, load_err}, 12'd0);
    prev = '{cnt: 12'h000, run: 1'b0, wr: 1'b0, le: 1'b0};
    mon_en = 1'b1;

    // Count: 40 RUN cycles give ten ticks, one on every 4th cycle.
    pulse(1, 0, 0, 0, 12'h000);
    push(12'h000, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
    begin
      logic [11:0] v;
      v = 12'h000;
      for (int i = 0; i < 10; i++) begin
        v = bcd_inc(v);
        push(v, 1, 0, 0);
      end
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (inc_en !== ((i % 4) == 3)) bad++;
      @(posedge clk); #1;
    end
    chk("inc_en_period_bad_cycles", 12'(bad), 12'd0);
    chk("count_after_40", count, 12'h010);

    // Pause at prescaler=2. The resume increments 2 cycles after the start edge.
    wait_cyc(2);
    push(12'h010, 0, 0, 0);
    pulse(0, 0, 1, 0, 12'h000);
    wait_cyc(20);
    chk("hold_count", count, 12'h010);
    push(12'h010, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
    chk("resume_inc_en_c1", {11'd0, inc_en}, 12'd0);
    push(12'h011, 1, 0, 0);
    wait_cyc(1);
    chk("resume_inc_en_c2", {11'd0, inc_en}, 12'd1);
    wait_cyc(1);

    // Stop on the tick cycle: the increment is dropped.
    wait_cyc(3);
    chk("tick_before_stop", {11'd0, inc_en}, 12'd1);
    push(12'h011, 0, 0, 0);
    pulse(0, 0, 1, 0, 12'h000);
    chk("stop_on_tick_count", count, 12'h011);
    push(12'h000, 0, 0, 0);
    pulse(1, 0, 0, 0, 12'h000);

    // A non-BCD preset is rejected with a 1-cycle load_err.
    push(12'h000, 0, 0, 1);
    push(12'h000, 0, 0, 0);
    pulse(0, 1, 0, 0, 12'h0A5);
    wait_cyc(1);
    chk("bad_load_count", count, 12'h000);

    // clear and load in the same cycle: clear wins.
    push(12'h047, 0, 0, 0);
    pulse(0, 1, 0, 0, 12'h047);
    push(12'h047, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
    push(12'h000, 0, 0, 0);
    pulse(1, 1, 0, 0, 12'h123);

`ifdef BCD_CTRL_SATURATE_EN
    // Saturate at 999: drop to HOLD, wrap never rises.
    push(12'h997, 0, 0, 0);
    pulse(0, 1, 0, 0, 12'h997);
    push(12'h997, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
    push(12'h998, 1, 0, 0);
    push(12'h999, 1, 0, 0);
    push(12'h999, 0, 0, 0);
    wait_cyc(11);
    chk("sat_inc_en_at_999", {11'd0, inc_en}, 12'd0);
    wait_cyc(5);
    chk("sat_count", count, 12'h999);
    chk("sat_running", {11'd0, running}, 12'd0);
    push(12'h047, 0, 0, 0);
    pulse(0, 1, 0, 0, 12'h047);
    push(12'h047, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
`else
    // Wrap 998 -> 999 -> 000. wrap is high for 1 cycle and running stays high.
    push(12'h998, 0, 0, 0);
    pulse(0, 1, 0, 0, 12'h998);
    push(12'h998, 1, 0, 0);
    pulse(0, 0, 0, 1, 12'h000);
    push(12'h999, 1, 0, 0);
    push(12'h000, 1, 1, 0);
    push(12'h000, 1, 0, 0);
    wait_cyc(9);
    chk("wrap_running", {11'd0, running}, 12'd1);
    push(12'h047, 1, 0, 0);
    pulse(0, 1, 0, 0, 12'h047);
    pulse(0, 0, 0, 1, 12'h000);
`endif

    // Reset mid-RUN with count=047 clears the outputs without a clock edge.
    wait_cyc(1);
    push(12'h000, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", count, 12'h000);
    chk("async_rst_running", {11'd0, running}, 12'd0);
    chk("async_rst_inc_en", {11'd0, inc_en}, 12'd0);
    #10 reset_n = 1'b1;
    wait_cyc(4);

    chk("scoreboard_drained", 12'(exp_q.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
